// File: rtl/axi_line_fetch.sv
// -----------------------------------------------------------------------------
// axi_line_fetch
//
// AXI4 read master that refills one cache line per request. A line request is
// accepted in IDLE, turned into a single INCR burst of LINE_WORDS beats on the
// AR channel, and the returned R beats are collected into a line buffer. The
// finished line is then held on the line_* outputs until downstream takes it.
// Only one request is in flight at a time.
//
// Parameters
//   LINE_WORDS  32-bit words per line (power of 2, 2..16); arlen = LINE_WORDS-1
//   OFF_W       byte-offset bits of a line, log2(LINE_WORDS*4)
//
// Ports
//   clk_i, rst_i        clock (rising edge) and synchronous active-high reset
//   req_valid_i/_ready_o, req_addr_i
//                       line request handshake; any byte address in the line
//   axi_ar*             AR channel: line-aligned start address, constant arlen
//   axi_r*              R channel: data, response, last, valid/ready
//   line_valid_o/_ready_i
//                       completed-line handshake towards downstream
//   line_addr_o         line-aligned address of the completed line
//   line_data_o         word k at bits [32k+31:32k], k = beat index
//   line_err_o          line is suspect (error response or rlast misplaced)
// -----------------------------------------------------------------------------
module axi_line_fetch #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned OFF_W      = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // line request
  input  logic                     req_valid_i,
  input  logic [31:0]              req_addr_i,
  output logic                     req_ready_o,
  // AXI read address channel
  output logic [31:0]              axi_araddr_o,
  output logic [7:0]               axi_arlen_o,
  output logic                     axi_arvalid_o,
  input  logic                     axi_arready_i,
  // AXI read data channel
  input  logic [31:0]              axi_rdata_i,
  input  logic [1:0]               axi_rresp_i,
  input  logic                     axi_rlast_i,
  input  logic                     axi_rvalid_i,
  output logic                     axi_rready_o,
  // completed line
  output logic                     line_valid_o,
  output logic [31:0]              line_addr_o,
  output logic [32*LINE_WORDS-1:0] line_data_o,
  output logic                     line_err_o,
  input  logic                     line_ready_i
);

  localparam int unsigned       CNT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);
  localparam logic [7:0]        ARLEN     = 8'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_AR    = 3'd1,
    S_RD    = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q;
  logic             req_ready_q;
  logic             arvalid_q;
  logic             rready_q;
  logic             line_valid_q;
  logic             err_q;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      words_q [LINE_WORDS];

  logic             req_hs_s;
  logic             r_hs_s;
  logic             beat_bad_s;
  logic             capture_s;
  logic [31:0]      line_base_s;
  logic             unused_off_s;

  // Handshake and beat qualifiers. rready_q is only ever high in RD/DRAIN, so
  // beats offered in any other state are never accepted.
  always_comb begin
    req_hs_s    = req_valid_i & req_ready_q;
    r_hs_s      = axi_rvalid_i & rready_q;
    beat_bad_s  = (axi_rresp_i != 2'b00);
    capture_s   = r_hs_s & (state_q == S_RD) & ~rst_i;
    line_base_s = {req_addr_i[31:OFF_W], {OFF_W{1'b0}}};
  end

  // The byte offset inside the line is intentionally ignored.
  assign unused_off_s = ^req_addr_i[OFF_W-1:0];

  // Control FSM with all handshake outputs registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      line_valid_q <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= 32'h0000_0000;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_hs_s) begin
            addr_q      <= line_base_s;
            err_q       <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            req_ready_q <= 1'b0;
            arvalid_q   <= 1'b1;
            state_q     <= S_AR;
          end
        end

        S_AR: begin
          // address and length stay put until the slave takes them
          if (axi_arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD;
          end
        end

        S_RD: begin
          if (r_hs_s) begin
            err_q <= err_q | beat_bad_s;
            if (cnt_q == LAST_BEAT) begin
              // counter parks on the last slot; it never wraps
              if (axi_rlast_i) begin
                rready_q     <= 1'b0;
                line_valid_q <= 1'b1;
                state_q      <= S_DONE;
              end else begin
                // slave is sending more than a line; swallow the rest
                err_q   <= 1'b1;
                state_q <= S_DRAIN;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (axi_rlast_i) begin
                // burst ended early; unwritten slots keep stale data
                err_q        <= 1'b1;
                rready_q     <= 1'b0;
                line_valid_q <= 1'b1;
                state_q      <= S_DONE;
              end
            end
          end
        end

        S_DRAIN: begin
          if (r_hs_s && axi_rlast_i) begin
            rready_q     <= 1'b0;
            line_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end

        S_DONE: begin
          if (line_ready_i) begin
            line_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end

        default: begin
          // unreachable encodings fall back to a clean idle
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          arvalid_q    <= 1'b0;
          rready_q     <= 1'b0;
          line_valid_q <= 1'b0;
          err_q        <= 1'b0;
          cnt_q        <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Line buffer: each accepted RD beat lands in the slot picked by the beat
  // counter. No reset; contents are meaningless until written.
  always_ff @(posedge clk_i) begin
    if (capture_s) begin
      words_q[cnt_q] <= axi_rdata_i;
    end
  end

  genvar k;
  generate
    for (k = 0; k < LINE_WORDS; k++) begin : g_line_out
      assign line_data_o[32*k +: 32] = words_q[k];
    end
  endgenerate

  assign req_ready_o   = req_ready_q;
  assign axi_araddr_o  = addr_q;
  assign axi_arlen_o   = ARLEN;
  assign axi_arvalid_o = arvalid_q;
  assign axi_rready_o  = rready_q;
  assign line_valid_o  = line_valid_q;
  assign line_addr_o   = addr_q;
  assign line_err_o    = err_q;

endmodule
